// File: rtl/slip_rx.sv
// slip_rx: SLIP (RFC 1055) receive decoder.
// Takes the encoded UART RX byte stream and emits decoded bytes on a
// valid/ready stream with last/err frame markers. A one-byte hold register
// delays each decoded byte so the frame's final byte can carry out_last.
// Optional SLIP_RX_STATS_EN adds saturating frame/error/drop counters.
module slip_rx #(
  parameter int unsigned MAX_LEN = 256,
  parameter int unsigned LEN_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [7:0]       out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             out_err,
  output logic [LEN_W-1:0] frame_len,
  output logic             err_esc,
  output logic             err_ovf
`ifdef SLIP_RX_STATS_EN
  ,
  output logic [15:0]      stat_frames,
  output logic [15:0]      stat_err,
  output logic [15:0]      stat_drop
`endif
);

  localparam logic [7:0] END_B   = 8'hC0;
  localparam logic [7:0] ESC_B   = 8'hDB;
  localparam logic [7:0] ESC_END = 8'hDC;
  localparam logic [7:0] ESC_ESC = 8'hDD;

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_ESC, S_DROP} state_t;

  state_t             state_q, state_d;
  logic [7:0]         hold_data_q, hold_data_d;
  logic               hold_vld_q, hold_vld_d;
  logic [LEN_W-1:0]   count_q, count_d;
  logic [7:0]         out_data_q, out_data_d;
  logic               out_valid_q, out_valid_d;
  logic               out_last_q, out_last_d;
  logic               out_err_q, out_err_d;
  logic [LEN_W-1:0]   frame_len_q, frame_len_d;
  logic               err_esc_q, err_esc_d;
  logic               err_ovf_q, err_ovf_d;

  logic       accept;
  logic       dat_vld;
  logic [7:0] dat_byte;
  logic       term_ok;
  logic       esc_bad;
  logic       drop;
  logic       ovf;
  logic       push, push_last, push_err;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign ovf      = dat_vld && (count_q == LEN_W'(MAX_LEN));

  // Classify the consumed byte into decode events for the current state
  always_comb begin
    dat_vld  = 1'b0;
    dat_byte = in_data;
    term_ok  = 1'b0;
    esc_bad  = 1'b0;
    drop     = 1'b0;
    if (accept) begin
      unique case (state_q)
        S_IDLE, S_DATA: begin
          if (in_data == END_B)      term_ok = (state_q == S_DATA);
          else if (in_data != ESC_B) dat_vld = 1'b1;
        end
        S_ESC: begin
          if (in_data == ESC_END) begin
            dat_vld  = 1'b1;
            dat_byte = END_B;
          end else if (in_data == ESC_ESC) begin
            dat_vld  = 1'b1;
            dat_byte = ESC_B;
          end else begin
            esc_bad = 1'b1;
          end
        end
        S_DROP: drop = (in_data != END_B);
        default: ;
      endcase
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (accept) begin
      unique case (state_q)
        S_IDLE, S_DATA: begin
          if (in_data == END_B)      state_d = S_IDLE;
          else if (in_data == ESC_B) state_d = S_ESC;
          else if (ovf)              state_d = S_DROP;
          else                       state_d = S_DATA;
        end
        S_ESC: begin
          if (dat_vld)               state_d = ovf ? S_DROP : S_DATA;
          else if (in_data == END_B) state_d = S_IDLE;
          else                       state_d = S_DROP;
        end
        S_DROP: if (in_data == END_B) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Datapath/output logic: hold register, length count, output beat, pulses
  always_comb begin
    hold_data_d = hold_data_q;
    hold_vld_d  = hold_vld_q;
    count_d     = count_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q && !out_ready;
    out_last_d  = out_last_q;
    out_err_d   = out_err_q;
    frame_len_d = frame_len_q;
    err_esc_d   = 1'b0;
    err_ovf_d   = 1'b0;
    push        = 1'b0;
    push_last   = 1'b0;
    push_err    = 1'b0;
    if (ovf) begin
      err_ovf_d  = 1'b1;
      push       = hold_vld_q;
      push_last  = 1'b1;
      push_err   = 1'b1;
      if (hold_vld_q) frame_len_d = count_q;
      count_d    = '0;
      hold_vld_d = 1'b0;
    end else if (dat_vld) begin
      push        = hold_vld_q;
      hold_data_d = dat_byte;
      hold_vld_d  = 1'b1;
      count_d     = count_q + LEN_W'(1);
    end else if (term_ok) begin
      push        = 1'b1;
      push_last   = 1'b1;
      frame_len_d = count_q;
      count_d     = '0;
      hold_vld_d  = 1'b0;
    end else if (esc_bad) begin
      err_esc_d  = 1'b1;
      push       = hold_vld_q;
      push_last  = 1'b1;
      push_err   = 1'b1;
      if (hold_vld_q) frame_len_d = count_q;
      count_d    = '0;
      hold_vld_d = 1'b0;
    end
    if (push) begin
      out_data_d  = hold_data_q;
      out_valid_d = 1'b1;
      out_last_d  = push_last;
      out_err_d   = push_err;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_data_q <= '0;
      hold_vld_q  <= 1'b0;
      count_q     <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_err_q   <= 1'b0;
      frame_len_q <= '0;
      err_esc_q   <= 1'b0;
      err_ovf_q   <= 1'b0;
    end else begin
      hold_data_q <= hold_data_d;
      hold_vld_q  <= hold_vld_d;
      count_q     <= count_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_err_q   <= out_err_d;
      frame_len_q <= frame_len_d;
      err_esc_q   <= err_esc_d;
      err_ovf_q   <= err_ovf_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_err   = out_err_q;
  assign frame_len = frame_len_q;
  assign err_esc   = err_esc_q;
  assign err_ovf   = err_ovf_q;

`ifdef SLIP_RX_STATS_EN
  logic [15:0] stat_frames_q, stat_frames_d;
  logic [15:0] stat_err_q, stat_err_d;
  logic [15:0] stat_drop_q, stat_drop_d;

  // Saturating statistics counters
  always_comb begin
    stat_frames_d = stat_frames_q;
    stat_err_d    = stat_err_q;
    stat_drop_d   = stat_drop_q;
    if (out_valid_q && out_ready && out_last_q && !out_err_q && stat_frames_q != '1)
      stat_frames_d = stat_frames_q + 16'd1;
    if ((err_esc_d || err_ovf_d) && stat_err_q != '1)
      stat_err_d = stat_err_q + 16'd1;
    if ((drop || ovf) && stat_drop_q != '1)
      stat_drop_d = stat_drop_q + 16'd1;
  end

  // Statistics registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_frames_q <= '0;
      stat_err_q    <= '0;
      stat_drop_q   <= '0;
    end else begin
      stat_frames_q <= stat_frames_d;
      stat_err_q    <= stat_err_d;
      stat_drop_q   <= stat_drop_d;
    end
  end

  assign stat_frames = stat_frames_q;
  assign stat_err    = stat_err_q;
  assign stat_drop   = stat_drop_q;
`endif

endmodule

// File: tb/tb_slip_rx.sv
// tb_slip_rx: scoreboard bench for slip_rx (MAX_LEN=4).
// Stimulus pushes expected beats into a queue; a monitor pops and compares
// every accepted output beat and counts error pulses.
module tb_slip_rx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        out_err;
  logic [15:0] frame_len;
  logic        err_esc;
  logic        err_ovf;

  int unsigned total  = 0;
  int unsigned passed = 0;
  int unsigned esc_cnt = 0;
  int unsigned ovf_cnt = 0;
  logic [9:0]  exp_q[$];

  slip_rx #(.MAX_LEN(4), .LEN_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .out_err(out_err), .frame_len(frame_len),
    .err_esc(err_esc), .err_ovf(err_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // expected beat: {data, last, err}
  task automatic expect_beat(input logic [7:0] d, input logic l, input logic e);
    exp_q.push_back({d, l, e});
  endtask

  // Called at a negedge; returns at the negedge after the byte is consumed
  task automatic send(input logic [7:0] b);
    int unsigned n;
    in_data  = b;
    in_valid = 1'b1;
    #1;
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk); #1;
      n++;
    end
    chk("in_ready_wait", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    repeat (4) @(negedge clk);
    chk("queue_empty", exp_q.size(), 32'd0);
  endtask

  // Monitor: compare each accepted beat, count pulses
  initial begin
    logic [9:0] e;
    forever begin
      @(negedge clk); #2;
      if (err_esc) esc_cnt++;
      if (err_ovf) ovf_cnt++;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          $display("FAIL unexpected_beat: got data=0x%0h last=%0b err=%0b expected none",
                   out_data, out_last, out_err);
        end else begin
          e = exp_q.pop_front();
          chk("beat", {22'd0, out_data, out_last, out_err}, {22'd0, e});
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    @(negedge clk); #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data",  {24'd0, out_data}, 32'd0);
    chk("rst_last_err",  {30'd0, out_last, out_err}, 32'd0);
    chk("rst_frame_len", {16'd0, frame_len}, 32'd0);
    chk("rst_pulses",    {30'd0, err_esc, err_ovf}, 32'd0);
    chk("rst_in_ready",  {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // basic frame
    expect_beat(8'h01, 1'b0, 1'b0);
    expect_beat(8'h02, 1'b1, 1'b0);
    send(8'hC0); send(8'h01); send(8'h02); send(8'hC0);
    drain();
    chk("len_basic", {16'd0, frame_len}, 32'd2);

    // escapes, exactly MAX_LEN bytes
    expect_beat(8'h41, 1'b0, 1'b0);
    expect_beat(8'hC0, 1'b0, 1'b0);
    expect_beat(8'hDB, 1'b0, 1'b0);
    expect_beat(8'h42, 1'b1, 1'b0);
    send(8'h41); send(8'hDB); send(8'hDC); send(8'hDB); send(8'hDD);
    send(8'h42); send(8'hC0);
    drain();
    chk("len_escape", {16'd0, frame_len}, 32'd4);
    chk("ovf_none_at_max", ovf_cnt, 32'd0);

    // empty frames
    send(8'hC0); send(8'hC0); send(8'hC0);
    drain();
    chk("empty_esc_pulses", esc_cnt, 32'd0);
    chk("empty_ovf_pulses", ovf_cnt, 32'd0);
    chk("empty_len", {16'd0, frame_len}, 32'd4);

    // illegal escape, drop, recovery
    expect_beat(8'h10, 1'b1, 1'b1);
    send(8'h10); send(8'hDB); send(8'h55);
    drain();
    chk("bad_esc_pulse", esc_cnt, 32'd1);
    chk("bad_esc_len", {16'd0, frame_len}, 32'd1);
    expect_beat(8'h20, 1'b1, 1'b0);
    send(8'h77); send(8'hC0); send(8'h20); send(8'hC0);
    drain();
    chk("recover_len", {16'd0, frame_len}, 32'd1);

    // overflow
    expect_beat(8'h01, 1'b0, 1'b0);
    expect_beat(8'h02, 1'b0, 1'b0);
    expect_beat(8'h03, 1'b0, 1'b0);
    expect_beat(8'h04, 1'b1, 1'b1);
    send(8'h01); send(8'h02); send(8'h03); send(8'h04); send(8'h05);
    send(8'h06); send(8'hC0);
    drain();
    chk("ovf_pulse", ovf_cnt, 32'd1);
    chk("ovf_len", {16'd0, frame_len}, 32'd4);
    chk("ovf_esc_unchanged", esc_cnt, 32'd1);

    // zero-byte escape error from idle
    send(8'hDB); send(8'h00); send(8'h00); send(8'hC0);
    drain();
    chk("zero_err_pulse", esc_cnt, 32'd2);
    chk("zero_err_len", {16'd0, frame_len}, 32'd4);

    // back-pressure
    expect_beat(8'hAA, 1'b0, 1'b0);
    expect_beat(8'hBB, 1'b1, 1'b0);
    send(8'hC0); send(8'hAA); send(8'hBB);
    out_ready = 1'b0;
    in_data   = 8'hC0;
    in_valid  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
      chk("stall_out_data", {23'd0, out_valid, out_data}, {23'd0, 1'b1, 8'hAA});
      @(negedge clk);
    end
    out_ready = 1'b1;
    send(8'hC0);
    drain();
    chk("stall_len", {16'd0, frame_len}, 32'd2);

    // reset mid-frame: held byte must never appear
    expect_beat(8'h11, 1'b0, 1'b0);
    send(8'h11); send(8'h22);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_len", {16'd0, frame_len}, 32'd0);
    chk("midrst_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    expect_beat(8'h33, 1'b1, 1'b0);
    send(8'h33); send(8'hC0);
    drain();
    chk("after_rst_len", {16'd0, frame_len}, 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
